// File: rtl/rc4_pkg.sv
// Shared types and helpers for the RC4 key-scheduling engine.
// Keys are handled left-aligned in a MAX_KEY_BYTES-wide vector so byte 0 is always the top byte.
package rc4_pkg;

    localparam int MAX_KEY_BYTES = 16;
    localparam int KEY_IDX_W     = 4;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FILL,
        ST_READ_I,
        ST_WAIT_I,
        ST_READ_J,
        ST_WAIT_J,
        ST_WRITE_I,
        ST_WRITE_J,
        ST_DONE
    } ksa_state_t;

    function automatic logic [7:0] key_byte(input logic [8*MAX_KEY_BYTES-1:0] key,
                                            input logic [KEY_IDX_W-1:0]       idx);
        logic [8*MAX_KEY_BYTES-1:0] shifted;
        shifted = key << {idx, 3'b000};
        return shifted[8*MAX_KEY_BYTES-1 -: 8];
    endfunction

endpackage

// File: rtl/rc4_ksa_engine_if.sv
// Single-port S memory bus between the KSA engine (master) and s_memory (slave).
interface rc4_ksa_engine_if #(
    parameter int ADDR_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic              mem_wren;
    logic [7:0]        mem_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_wren,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_wren,
        output mem_rdata
    );
endinterface

// File: rtl/rc4_ksa_engine_key_mux.sv
// Selects key[i mod KEY_BYTES] from the latched key using a wrapping index counter
// that steps once per swap iteration.
module ksa_key_mux
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = 3
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic [8*KEY_BYTES-1:0] key,
    input  logic                   idx_clear,
    input  logic                   idx_advance,
    output logic [7:0]             key_sel
);
    localparam logic [KEY_IDX_W-1:0] IDX_LAST = KEY_IDX_W'(KEY_BYTES - 1);

    logic [KEY_IDX_W-1:0]       idx_reg;
    logic [8*MAX_KEY_BYTES-1:0] key_aligned;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            idx_reg <= '0;
        end else if (idx_clear) begin
            idx_reg <= '0;
        end else if (idx_advance) begin
            idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + KEY_IDX_W'(1);
        end
    end

    assign key_aligned = (8*MAX_KEY_BYTES)'(key) << (8 * (MAX_KEY_BYTES - KEY_BYTES));
    assign key_sel     = key_byte(key_aligned, idx_reg);

endmodule

// File: rtl/rc4_ksa_engine.sv
// RC4 key-scheduling engine: fills the external S memory with S[i]=i, then runs the KSA swap loop.
// Each state issues its memory access on the registered bus, which is seen by s_memory the next cycle.
module rc4_ksa_engine
    import rc4_pkg::*;
#(
    parameter int KEY_BYTES = 3,
    parameter int ADDR_W    = 8
) (
    input  logic                    CLOCK_50,
    input  logic                    reset,
    input  logic                    start,
    input  logic [8*KEY_BYTES-1:0]  secret_key,
    rc4_ksa_engine_if.master        mem,
    output logic                    busy,
    output logic                    done
);
    localparam logic [ADDR_W-1:0] I_LAST = '1;

    ksa_state_t             state_reg;
    logic [ADDR_W-1:0]      i_reg;
    logic [ADDR_W-1:0]      j_reg;
    logic [7:0]             s_i_reg;
    logic [8*KEY_BYTES-1:0] key_reg;
    logic [ADDR_W-1:0]      mem_addr_reg;
    logic [7:0]             mem_wdata_reg;
    logic                   mem_wren_reg;
    logic                   busy_reg;
    logic                   done_reg;

    logic [ADDR_W-1:0]      i_inc;
    logic [ADDR_W-1:0]      j_sum;
    logic [7:0]             key_sel;
    logic                   accept;
    logic                   idx_clear;
    logic                   idx_advance;

    // The first DONE cycle still carries the final swap write, so start is only taken once done is up.
    assign accept      = start && ((state_reg == ST_IDLE) || ((state_reg == ST_DONE) && done_reg));
    assign i_inc       = i_reg + ADDR_W'(1);
    assign j_sum       = j_reg + mem.mem_rdata[ADDR_W-1:0] + key_sel[ADDR_W-1:0];
    assign idx_clear   = (state_reg == ST_FILL);
    assign idx_advance = (state_reg == ST_WRITE_J);

    ksa_key_mux #(
        .KEY_BYTES (KEY_BYTES)
    ) u_key_mux (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .key         (key_reg),
        .idx_clear   (idx_clear),
        .idx_advance (idx_advance),
        .key_sel     (key_sel)
    );

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            i_reg         <= '0;
            j_reg         <= '0;
            s_i_reg       <= '0;
            key_reg       <= '0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_wren_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE, ST_DONE: begin
                    if (accept) begin
                        key_reg       <= secret_key;
                        i_reg         <= '0;
                        j_reg         <= '0;
                        mem_addr_reg  <= '0;
                        mem_wdata_reg <= '0;
                        mem_wren_reg  <= 1'b1;
                        busy_reg      <= 1'b1;
                        done_reg      <= 1'b0;
                        state_reg     <= ST_FILL;
                    end else if (state_reg == ST_DONE) begin
                        mem_wren_reg <= 1'b0;
                        busy_reg     <= 1'b0;
                        done_reg     <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (i_reg == I_LAST) begin
                        i_reg        <= '0;
                        mem_wren_reg <= 1'b0;
                        state_reg    <= ST_READ_I;
                    end else begin
                        i_reg         <= i_inc;
                        mem_addr_reg  <= i_inc;
                        mem_wdata_reg <= 8'(i_inc);
                    end
                end
                ST_READ_I: begin
                    mem_addr_reg <= i_reg;
                    mem_wren_reg <= 1'b0;
                    state_reg    <= ST_WAIT_I;
                end
                ST_WAIT_I: begin
                    state_reg <= ST_READ_J;
                end
                ST_READ_J: begin
                    s_i_reg      <= mem.mem_rdata;
                    j_reg        <= j_sum;
                    mem_addr_reg <= j_sum;
                    state_reg    <= ST_WAIT_J;
                end
                ST_WAIT_J: begin
                    state_reg <= ST_WRITE_I;
                end
                ST_WRITE_I: begin
                    mem_addr_reg  <= i_reg;
                    mem_wdata_reg <= mem.mem_rdata;
                    mem_wren_reg  <= 1'b1;
                    state_reg     <= ST_WRITE_J;
                end
                ST_WRITE_J: begin
                    // When i==j this rewrites the value just written, leaving S unchanged.
                    mem_addr_reg  <= j_reg;
                    mem_wdata_reg <= s_i_reg;
                    mem_wren_reg  <= 1'b1;
                    if (i_reg == I_LAST) begin
                        state_reg <= ST_DONE;
                    end else begin
                        i_reg     <= i_inc;
                        state_reg <= ST_READ_I;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign mem.mem_addr  = mem_addr_reg;
    assign mem.mem_wdata = mem_wdata_reg;
    assign mem.mem_wren  = mem_wren_reg;
    assign busy          = busy_reg;
    assign done          = done_reg;

endmodule

// File: doc/rc4_ksa_engine.md
# rc4_ksa_engine

Parametrised RC4 key-scheduling engine for the cracker datapath. It drives an external single-port S memory (`s_memory`) to fill S[i] = i, then performs the full KSA swap loop over an N-entry state array using a KEY_BYTES-wide secret key. It generalises the fixed 3-byte / 256-entry scheduler with configurable key length and array depth, a start/done handshake, a key latch and correct loop termination. It sits between the key-search controller and the PRGA/decrypt stage.

## Interface
- KEY_BYTES, default 3: secret key length in bytes, 1..16.
- ADDR_W, default 8: S address width; N = 2**ADDR_W entries, 2..8.
- CLOCK_50  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-high; forces IDLE and clears all outputs.
- start  in  1  one-cycle request; accepted only in IDLE or DONE.
- secret_key  in  8*KEY_BYTES  key; byte 0 = most-significant byte; latched on accepted start.
- mem_addr  out  ADDR_W  S memory address (registered).
- mem_wdata  out  8  S memory write data (registered).
- mem_wren  out  1  S memory write enable (registered).
- mem_rdata  in  8  S memory read data; valid in the 2nd cycle after mem_addr changes.
- busy  out  1  high from accepted start until DONE.
- done  out  1  high in DONE, held until next accepted start or reset.

## Operation
- States: IDLE, FILL, READ_I, WAIT_I, READ_J, WAIT_J, WRITE_I, WRITE_J, DONE.
- IDLE/DONE + start: latch key, i=0, j=0, busy=1, done=0, go to FILL.
- FILL: each cycle write addr=i, data=i, wren=1. At i==N-1 write, clear i, go to READ_I. Terminate on i==N-1; never compare an ADDR_W counter against N.
- READ_I: mem_addr=i, wren=0.
- WAIT_I: hold.
- READ_J: S_i=mem_rdata; j = j + S_i + key[i mod KEY_BYTES] (mod N, operands truncated to ADDR_W); mem_addr = new j.
- WAIT_J: hold.
- WRITE_I: S_j=mem_rdata; write addr=i, data=S_j.
- WRITE_J: write addr=j, data=S_i. If i==N-1, go to DONE. Otherwise i++ and go to READ_I.
- i==j: both writes hit the same address with equal data. The result must be unchanged S.
- key[k] = secret_key[8*(KEY_BYTES-k)-1 -: 8]. The key-index counter wraps at KEY_BYTES and is reset at the start of the swap phase.
- start while busy is ignored. secret_key changes while busy have no effect.
- DONE: wren=0, busy=0, done=1.

## Timing
- Reset values: mem_addr=0, mem_wdata=0, mem_wren=0, busy=0, done=0, state IDLE.
- Reset mid-operation aborts immediately. S memory contents are then undefined; no further writes occur.
- First FILL write is on the edge after start is sampled.
- Latency from start to done rising = N (fill) + 6N (swap) + 1 cycles. For N=256 this is 1793 cycles.
- Exactly one memory access per cycle; wren is high only in FILL, WRITE_I and WRITE_J.

## Structure
- Package `rc4_pkg` holds:
  - the ksa state enum type;
  - function `key_byte(key, idx)`;
  - constant MAX_KEY_BYTES = 16.
- One sub-module is natural: `ksa_key_mux`, a combinational byte selector for key[i mod KEY_BYTES] with a registered index counter.
- `s_memory` is instantiated by the parent, not inside this block.

## Test plan
- Reset values: assert reset mid-swap (~cycle 500) -> all outputs 0 within the same cycle, state IDLE; a following start completes normally.
- Fill phase, ADDR_W=8, any key: mem_wren high for 256 consecutive cycles with addr=data=0..255, then low in READ_I.
- Swap result, ADDR_W=2, KEY_BYTES=1, key=8'h00: final S = [0,2,3,1]. Bench checks j sequence 0,1,3,1 and the i==j swaps at i=0,1.
- Full-size vectors, ADDR_W=8, KEY_BYTES=3, keys 24'h000000 and 24'h0003FF: final S matches the software RC4 KSA golden model; done rises exactly 1793 cycles after start.
- Handshake: pulse start during busy, and change secret_key at cycle 10 -> no restart, result equals the original-key golden S; done holds until the next start, which clears done in 1 cycle.
- KEY_BYTES=5, ADDR_W=8: key indexing wraps correctly (i=5 uses byte 0); result matches the golden model.
